// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      SQUASH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

   // Redirect targets are word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   // Sequential PC step, modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Latency: n/a (wires only).
// Backpressure: req is held until ack; ack with req low means nothing.
//
// Signals:
//   req   fetch -> imem  request, held until ack
//   addr  fetch -> imem  word address, stable while req=1 and no ack
//   ack   imem  -> fetch rdata valid this cycle, ends the request
//   rdata imem  -> fetch fetched instruction word
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry holding register for a word acked while decode is stalled.
// Latency: loaded word visible the cycle after load.
// Backpressure: none; clear wins over load.
//
// Ports: clk, reset (async active-low), load/din capture a word,
//        clear empties the entry, dout/valid expose the stored word.
module fetch_hold_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout  <= DEFAULT_NOP_INSTR;
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         dout  <= din;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem, drives the IF/ID register.
// Latency: one instruction per cycle with 0-wait memory; IF/ID loads on the edge that sees ack.
// Backpressure: stall_id freezes IF/ID and PC; a word acked during stall parks in the hold buffer.
//
// Ports:
//   clk, reset (async active-low)
//   stall_id              decode stall
//   redirect, redirect_pc taken branch/jump and its target (low two bits ignored)
//   imem                  fetch_unit_if.master request/response to instruction memory
//   instruction, pc_plus4, if_valid   IF/ID register contents
// Optional macro FETCH_PERF_EN adds fetch_count / bubble_count performance counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall_id,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   fetch_unit_if.master imem,
   output logic [31:0]  instruction,
   output logic [31:0]  pc_plus4,
   output logic         if_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  fetch_count,
   output logic [31:0]  bubble_count
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  sq_addr_q, sq_addr_d;   // address of the abandoned request while squashing
   ifid_t        ifid_q, ifid_d;
   ifid_t        bubble;
   logic         ifid_load;
   logic         req;
   logic         acked;
   logic         hold_load, hold_clear;
   logic [31:0]  hold_dat;
   logic         hold_vld;

   fetch_hold_buffer u_hold (
      .clk   (clk),
      .reset (reset),
      .load  (hold_load),
      .clear (hold_clear),
      .din   (imem.rdata),
      .dout  (hold_dat),
      .valid (hold_vld)
   );

   // Request is a pure function of state so reset drops it asynchronously.
   assign req        = (state_q == FETCH) || (state_q == SQUASH);
   assign acked      = req && imem.ack;
   assign imem.req   = req;
   // A squashed request keeps its original address until memory acks it.
   assign imem.addr  = (state_q == SQUASH) ? sq_addr_q : pc_q;

   assign instruction = ifid_q.instruction;
   assign pc_plus4    = ifid_q.pc_plus4;
   assign if_valid    = ifid_q.valid;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      sq_addr_d  = sq_addr_q;
      ifid_d     = ifid_q;
      ifid_load  = 1'b0;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      bubble     = '{instruction: NOP_INSTR, pc_plus4: ifid_q.pc_plus4, valid: 1'b0};

      if (redirect) begin
         // Redirect beats stall: flush IF/ID, drop any parked word.
         pc_d       = word_align(redirect_pc);
         ifid_d     = bubble;
         ifid_load  = 1'b1;
         hold_clear = 1'b1;
         case (state_q)
            FETCH: begin
               if (!acked) begin
                  state_d   = SQUASH;
                  sq_addr_d = pc_q;
               end else begin
                  state_d = FETCH;
               end
            end
            // An ack in the same cycle still ends the old request.
            SQUASH:  state_d = acked ? FETCH : SQUASH;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (acked && !stall_id) begin
                  ifid_d    = '{instruction: imem.rdata, pc_plus4: next_pc(pc_q), valid: 1'b1};
                  ifid_load = 1'b1;
                  pc_d      = next_pc(pc_q);
               end else if (acked) begin
                  hold_load = 1'b1;
                  state_d   = HOLD;
               end else if (!stall_id) begin
                  ifid_d    = bubble;
                  ifid_load = 1'b1;
               end
            end
            HOLD: begin
               if (!stall_id && hold_vld) begin
                  ifid_d     = '{instruction: hold_dat, pc_plus4: next_pc(pc_q), valid: 1'b1};
                  ifid_load  = 1'b1;
                  pc_d       = next_pc(pc_q);
                  hold_clear = 1'b1;
                  state_d    = FETCH;
               end
            end
            SQUASH: begin
               // Acked data belongs to the discarded path and is never used.
               if (!stall_id) begin
                  ifid_d    = bubble;
                  ifid_load = 1'b1;
               end
               if (acked) state_d = FETCH;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         sq_addr_q <= RESET_PC;
         ifid_q    <= '{instruction: NOP_INSTR, pc_plus4: RESET_PC, valid: 1'b0};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         sq_addr_q <= sq_addr_d;
         if (ifid_load) ifid_q <= ifid_d;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count  <= 32'd0;
         bubble_count <= 32'd0;
      end else if (ifid_load) begin
         if (ifid_d.valid) fetch_count  <= fetch_count + 32'd1;
         else              bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule
